// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the configurable UART receiver:
//   - parity-mode encodings for parity_mode_i
//   - receive FSM state encoding
//   - maj3(): 2-of-3 majority vote used for every bit decision
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } rx_state_e;

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through synchronous FIFO for received frames.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-low reset
//   push_i/wdata_i write request and data (ignored when full without pop)
//   pop_i          read request (ignored when empty)
//   rdata_o        head entry, reads 0 while empty
//   empty_o/full_o occupancy flags
//   level_o        number of entries held
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int               AW       = $clog2(DEPTH);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [AW:0]      LVL_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]      LVL_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      level_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LVL_FULL);
   assign do_pop  = pop_i && !empty_o;
   // A push into a full FIFO is still accepted when the head leaves this cycle.
   assign do_push = push_i && (!full_o || do_pop);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; only pointers and level are.
   // The head is gated with empty_o so the output still reads 0 after reset.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
// Configurable UART receiver: DATA_W data bits LSB first, runtime parity
// (none/even/odd) and 1/2 stop bits, 3-sample majority per bit, break
// detection, FWFT receive FIFO with sticky overrun.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   baud_tick_i             OVERSAMPLE x baud strobe
//   rx_serial_i             asynchronous serial line, idle high
//   parity_mode_i           00 none, 01 even, 10 odd, 11 none
//   stop_bits_i             0 = one stop bit, 1 = two
//   rx_data_o/rx_parity_err_o/rx_valid_o/rx_ready_i  FIFO head handshake
//   rx_frame_err_o, rx_break_o  one-cycle error pulses
//   rx_overrun_o/overrun_clr_i  sticky overrun and its clear
//   rx_busy_o               frame in progress
//   fifo_level_o            entries held
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
   parameter int DATA_W     = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        baud_tick_i,
   input  logic                        rx_serial_i,
   input  logic [1:0]                  parity_mode_i,
   input  logic                        stop_bits_i,
   output logic [DATA_W-1:0]           rx_data_o,
   output logic                        rx_parity_err_o,
   output logic                        rx_valid_o,
   input  logic                        rx_ready_i,
   output logic                        rx_frame_err_o,
   output logic                        rx_break_o,
   output logic                        rx_overrun_o,
   input  logic                        overrun_clr_i,
   output logic                        rx_busy_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

   import uart_pkg::*;

   localparam int                TICK_W   = $clog2(OVERSAMPLE);
   localparam int                CNT_W    = $clog2(DATA_W + 1);
   localparam logic [TICK_W-1:0] T_ONE    = TICK_W'(1);
   localparam logic [TICK_W-1:0] T_FIRST  = TICK_W'(OVERSAMPLE / 2 - 2);
   localparam logic [TICK_W-1:0] T_MID    = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] T_DECIDE = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] T_LAST   = TICK_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(DATA_W - 1);

   rx_state_e          state_q, state_d;
   logic [2:0]         sync_q;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [1:0]         samp_q, samp_d;
   logic [DATA_W-1:0]  shreg_q, shreg_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               par_err_q, par_err_d;
   logic               par_bit_q, par_bit_d;
   logic               stop_idx_q, stop_idx_d;
   logic [1:0]         par_mode_q, par_mode_d;
   logic               stop2_q, stop2_d;
   logic               busy_q, frame_err_q, break_q, overrun_q;
   logic               frame_err_d, break_d, push_req;

   logic rx_s, decide, bit_end, bit_val, par_en, par_exp, break_pat;
   logic stop_fail, stop_ok_last, fifo_full, fifo_empty, pop, overrun_set;

   assign rx_s      = sync_q[2];
   assign decide    = baud_tick_i && (tick_q == T_DECIDE);
   assign bit_end   = baud_tick_i && (tick_q == T_LAST);
   // Samples from ticks M-1 and M are held; tick M+1 is the live input.
   assign bit_val   = maj3({rx_s, samp_q});
   assign par_en    = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);
   assign par_exp   = (^shreg_q) ^ (par_mode_q == PAR_ODD);
   // A break is a line low from the start bit through the failing stop bit,
   // so a second-stop failure after a good first stop is a framing error.
   assign break_pat = (shreg_q == '0) && (!par_en || !par_bit_q) && !stop_idx_q;
   assign stop_fail    = decide && !bit_val;
   assign stop_ok_last = decide && bit_val && (!stop2_q || stop_idx_q);

   // ---------------- state register ----------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync_q      <= 3'b111;
         state_q     <= ST_IDLE;
         tick_q      <= '0;
         samp_q      <= 2'b11;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         par_err_q   <= 1'b0;
         par_bit_q   <= 1'b0;
         stop_idx_q  <= 1'b0;
         par_mode_q  <= PAR_NONE;
         stop2_q     <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         break_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync_q      <= {sync_q[1:0], rx_serial_i};
         state_q     <= state_d;
         tick_q      <= tick_d;
         samp_q      <= samp_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         par_err_q   <= par_err_d;
         par_bit_q   <= par_bit_d;
         stop_idx_q  <= stop_idx_d;
         par_mode_q  <= par_mode_d;
         stop2_q     <= stop2_d;
         busy_q      <= (state_q != ST_IDLE);
         frame_err_q <= frame_err_d;
         break_q     <= break_d;
         // Setting wins over a clear in the same cycle.
         overrun_q   <= overrun_set ? 1'b1 : (overrun_clr_i ? 1'b0 : overrun_q);
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      // NOTE: every _d defaults to its _q first, so no path infers a latch.
      state_d    = state_q;
      tick_d     = tick_q;
      samp_d     = samp_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      par_err_d  = par_err_q;
      par_bit_d  = par_bit_q;
      stop_idx_d = stop_idx_q;
      par_mode_d = par_mode_q;
      stop2_d    = stop2_q;

      if (baud_tick_i) begin
         tick_d = (tick_q == T_LAST) ? '0 : tick_q + T_ONE;
         if (tick_q == T_FIRST) samp_d[0] = rx_s;
         if (tick_q == T_MID)   samp_d[1] = rx_s;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (baud_tick_i && !rx_s) begin
               state_d    = ST_START;
               tick_d     = T_ONE;
               par_mode_d = parity_mode_i;
               stop2_d    = stop_bits_i;
               bit_cnt_d  = '0;
               stop_idx_d = 1'b0;
               par_err_d  = 1'b0;
               par_bit_d  = 1'b0;
            end
         end
         ST_START: begin
            if (decide && bit_val) state_d = ST_IDLE;
            else if (bit_end)      state_d = ST_DATA;
         end
         ST_DATA: begin
            if (decide) shreg_d = {bit_val, shreg_q[DATA_W-1:1]};
            if (bit_end) begin
               if (bit_cnt_q == BIT_LAST) state_d = par_en ? ST_PARITY : ST_STOP;
               else                       bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
         end
         ST_PARITY: begin
            if (decide) begin
               par_bit_d = bit_val;
               par_err_d = (bit_val != par_exp);
            end
            if (bit_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (stop_fail)         state_d = ST_WAIT_IDLE;
            else if (stop_ok_last) state_d = ST_IDLE;
            else if (bit_end)      stop_idx_d = 1'b1;
         end
         ST_WAIT_IDLE: begin
            if (baud_tick_i && rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Every return to IDLE (including the early exit half-way through the
      // final stop bit) restarts the bit timer.
      if (state_d == ST_IDLE) tick_d = '0;
   end

   // ---------------- output logic ----------------
   always_comb begin
      push_req    = 1'b0;
      frame_err_d = 1'b0;
      break_d     = 1'b0;
      if (state_q == ST_STOP) begin
         if (stop_fail) begin
            if (break_pat) break_d     = 1'b1;
            else           frame_err_d = 1'b1;
         end else if (stop_ok_last) begin
            push_req = 1'b1;
         end
      end
   end

   assign pop         = rx_valid_o && rx_ready_i;
   assign overrun_set = push_req && fifo_full && !pop;

   uart_rx_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push_req),
      .wdata_i ({par_err_q, shreg_q}),
      .pop_i   (pop),
      .rdata_o ({rx_parity_err_o, rx_data_o}),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .level_o (fifo_level_o)
   );

   assign rx_valid_o     = !fifo_empty;
   assign rx_frame_err_o = frame_err_q;
   assign rx_break_o     = break_q;
   assign rx_overrun_o   = overrun_q;
   assign rx_busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg
// Directed bench for uart_rx_cfg (DATA_W=8, OVERSAMPLE=16, FIFO_DEPTH=4).
// One baud tick every 4 clocks; the serial line is driven per tick slot.
// A negedge monitor records popped entries and counts error pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

   localparam int DATA_W     = 8;
   localparam int OVERSAMPLE = 16;
   localparam int FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       baud_tick;
   logic       rx;
   logic [1:0] parity_mode;
   logic       stop_bits;
   logic       rx_ready;
   logic       overrun_clr;

   logic [DATA_W-1:0]           rx_data;
   logic                        rx_parity_err, rx_valid, rx_frame_err, rx_break;
   logic                        rx_overrun, rx_busy;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;

   int n_tests = 0;
   int n_fail  = 0;
   int fe_cnt  = 0;
   int brk_cnt = 0;
   int fe0, brk0;
   logic [8:0] pop_q[$];

   always #5 clk = ~clk;

   uart_rx_cfg #(
      .DATA_W     (DATA_W),
      .OVERSAMPLE (OVERSAMPLE),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_n),
      .baud_tick_i     (baud_tick),
      .rx_serial_i     (rx),
      .parity_mode_i   (parity_mode),
      .stop_bits_i     (stop_bits),
      .rx_data_o       (rx_data),
      .rx_parity_err_o (rx_parity_err),
      .rx_valid_o      (rx_valid),
      .rx_ready_i      (rx_ready),
      .rx_frame_err_o  (rx_frame_err),
      .rx_break_o      (rx_break),
      .rx_overrun_o    (rx_overrun),
      .overrun_clr_i   (overrun_clr),
      .rx_busy_o       (rx_busy),
      .fifo_level_o    (fifo_level)
   );

   always @(negedge clk) begin
      if (rx_frame_err) fe_cnt <= fe_cnt + 1;
      if (rx_break)     brk_cnt <= brk_cnt + 1;
      if (rx_valid && rx_ready) pop_q.push_back({rx_parity_err, rx_data});
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One baud-tick slot: the value driven here is seen by the DUT's next tick.
   task automatic slot(input logic v, input logic rdy_pulse);
      rx        = v;
      baud_tick = 1'b1;
      if (rdy_pulse) rx_ready = 1'b1;
      @(posedge clk); #1;
      baud_tick = 1'b0;
      if (rdy_pulse) rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) slot(1'b1, 1'b0);
   endtask

   // bits[0] is the start bit. glitch pulls slot 7 of each data bit low;
   // pop_at_decide raises ready for the tick that decides the last stop bit.
   task automatic send_bits(input logic [12:0] bits, input int n, input bit glitch,
                            input bit pop_at_decide);
      for (int i = 0; i < n; i++)
         for (int j = 0; j < OVERSAMPLE; j++)
            slot((glitch && i >= 1 && i <= DATA_W && j == 7) ? 1'b0 : bits[i],
                 pop_at_decide && (i == n - 1) && (j == OVERSAMPLE / 2 + 1));
   endtask

   function automatic logic [12:0] f8n1(input logic [7:0] d);
      return {4'b0001, d, 1'b0};
   endfunction

   initial begin
      rst_n = 1'b0; rx = 1'b1; baud_tick = 1'b0; parity_mode = 2'b00;
      stop_bits = 1'b0; rx_ready = 1'b0; overrun_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", rx_data, 0);
      check("rst_perr", rx_parity_err, 0);
      check("rst_valid", rx_valid, 0);
      check("rst_ferr", rx_frame_err, 0);
      check("rst_break", rx_break, 0);
      check("rst_ovr", rx_overrun, 0);
      check("rst_busy", rx_busy, 0);
      check("rst_level", fifo_level, 0);
      rst_n = 1'b1;
      idle(4);

      // 8N1, two frames, consumer always ready
      rx_ready = 1'b1;
      send_bits(f8n1(8'hA5), 10, 0, 0); idle(4);
      send_bits(f8n1(8'h3C), 10, 0, 0); idle(4);
      check("8n1_count", pop_q.size(), 2);
      check("8n1_a5", pop_q[0], 16'h0A5);
      check("8n1_3c", pop_q[1], 16'h03C);
      check("8n1_ferr", fe_cnt, 0);
      check("8n1_brk", brk_cnt, 0);

      // Even parity, bit 0 on 0x07 (three ones) -> error; odd parity -> fine
      parity_mode = 2'b01;
      send_bits({3'b001, 1'b0, 8'h07, 1'b0}, 11, 0, 0); idle(4);
      parity_mode = 2'b10;
      send_bits({3'b001, 1'b0, 8'h07, 1'b0}, 11, 0, 0); idle(4);
      check("par_even_err", pop_q[2], 16'h107);
      check("par_odd_ok", pop_q[3], 16'h007);

      // Glitched data bits, then a short low pulse on the idle line
      parity_mode = 2'b00;
      send_bits(f8n1(8'hFF), 10, 1, 0); idle(4);
      check("glitch_ff", pop_q[4], 16'h0FF);
      repeat (4) slot(1'b0, 1'b0);
      idle(2);
      check("pulse_busy_hi", rx_busy, 1);
      idle(16);
      check("pulse_busy_lo", rx_busy, 0);
      check("pulse_noframe", pop_q.size(), 5);

      // 8N2 with bad second stop bit, then a good 8N2 frame
      stop_bits = 1'b1;
      fe0 = fe_cnt; brk0 = brk_cnt;
      send_bits({2'b00, 1'b0, 1'b1, 8'h55, 1'b0}, 11, 0, 0);
      check("8n2_ferr", fe_cnt - fe0, 1);
      check("8n2_nobrk", brk_cnt - brk0, 0);
      check("8n2_level", fifo_level, 0);
      idle(4);
      send_bits({2'b00, 1'b1, 1'b1, 8'h12, 1'b0}, 11, 0, 0); idle(4);
      check("8n2_count", pop_q.size(), 6);
      check("8n2_12", pop_q[5], 16'h012);
      check("8n2_ferr_once", fe_cnt - fe0, 1);

      // Break: line low for two frame times
      stop_bits = 1'b0;
      fe0 = fe_cnt; brk0 = brk_cnt;
      repeat (2 * 10 * OVERSAMPLE) slot(1'b0, 1'b0);
      idle(4);
      check("brk_pulse", brk_cnt - brk0, 1);
      check("brk_noferr", fe_cnt - fe0, 0);
      check("brk_nopush", pop_q.size(), 6);
      send_bits(f8n1(8'h81), 10, 0, 0); idle(4);
      check("brk_resume", pop_q[6], 16'h081);

      // FIFO fill and overrun
      rx_ready = 1'b0;
      send_bits(f8n1(8'h11), 10, 0, 0); idle(2);
      send_bits(f8n1(8'h22), 10, 0, 0); idle(2);
      send_bits(f8n1(8'h33), 10, 0, 0); idle(2);
      send_bits(f8n1(8'h44), 10, 0, 0); idle(2);
      check("fifo_ovr_before", rx_overrun, 0);
      send_bits(f8n1(8'h55), 10, 0, 0); idle(2);
      check("fifo_level4", fifo_level, 4);
      check("fifo_ovr_set", rx_overrun, 1);
      check("fifo_head", rx_data, 16'h011);
      check("fifo_valid", rx_valid, 1);
      overrun_clr = 1'b1;
      @(posedge clk); #1;
      overrun_clr = 1'b0;
      check("fifo_ovr_clr", rx_overrun, 0);
      send_bits(f8n1(8'h66), 10, 0, 1); idle(2);
      check("pp_level", fifo_level, 4);
      check("pp_no_ovr", rx_overrun, 0);
      check("pp_head", rx_data, 16'h022);
      check("pp_popped", pop_q[7], 16'h011);

      // Reset in the middle of a frame with a full FIFO
      send_bits(f8n1(8'h00), 3, 0, 0);
      check("mid_busy", rx_busy, 1);
      rst_n = 1'b0;
      #2;
      check("mid_rst_level", fifo_level, 0);
      check("mid_rst_valid", rx_valid, 0);
      check("mid_rst_busy", rx_busy, 0);
      check("mid_rst_data", rx_data, 0);
      rx = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      fe0 = fe_cnt; brk0 = brk_cnt;
      idle(4);
      check("mid_after_busy", rx_busy, 0);
      check("mid_no_flags", (fe_cnt - fe0) + (brk_cnt - brk0), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
